// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding and default parameters for the CPU sequencer.
package cpu_ctrl_pkg;

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_EXECUTE = 3'd1;
  localparam logic [2:0] ST_MTRAP   = 3'd2;
  localparam logic [2:0] ST_STRAP   = 3'd3;
  localparam logic [2:0] ST_FAULT   = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH   = ST_FETCH,
    S_EXECUTE = ST_EXECUTE,
    S_MTRAP   = ST_MTRAP,
    S_STRAP   = ST_STRAP,
    S_FAULT   = ST_FAULT
  } state_e;

  localparam int unsigned OPC_W_DEF   = 32;
  localparam int unsigned LS_LO_DEF   = 27;
  localparam int unsigned LS_HI_DEF   = 34;
  localparam int unsigned DR_LO_DEF   = 14;
  localparam int unsigned DR_HI_DEF   = 17;
  localparam int unsigned TMO_W_DEF   = 8;
  localparam int unsigned TMO_MAX_DEF = 200;

endpackage

// File: rtl/bus_watchdog.sv
// Saturating bus-wait counter; flags expiry when an increment is due at the last count.
module bus_watchdog
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TMO_W   = TMO_W_DEF,
  parameter int unsigned TMO_MAX = TMO_MAX_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire_c
);

  localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TMO_MAX - 1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry depends only on the enable and the stored count, never on the clear.
  assign o_expire_c = i_en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer with long-latency holds, boundary interrupts and a bus watchdog.
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W   = OPC_W_DEF,
  parameter int unsigned LS_LO   = LS_LO_DEF,
  parameter int unsigned LS_HI   = LS_HI_DEF,
  parameter int unsigned DR_LO   = DR_LO_DEF,
  parameter int unsigned DR_HI   = DR_HI_DEF,
  parameter int unsigned TMO_W   = TMO_W_DEF,
  parameter int unsigned TMO_MAX = TMO_MAX_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bus_DV,
  input  logic [OPC_W-1:0] i_instruction,
  input  logic             i_div_rem_finnished,
  input  logic             i_m_interrupt,
  input  logic             i_s_interrupt,
  input  logic             i_m_ie,
  input  logic             i_s_ie,
  input  logic             i_interrupt_finnished,
  input  logic             i_fault_clear,
  output logic             o_load_PC,
  output logic             o_start_fetch,
  output logic [2:0]       o_state,
  output logic             o_irq_ack_m,
  output logic             o_irq_ack_s,
  output logic             o_bus_timeout
);

  state_e state_q, state_d;
  logic   start_fetch_q, start_fetch_d;
  logic   ack_m_q, ack_m_d;
  logic   ack_s_q, ack_s_d;
  logic   timeout_q, timeout_d;

  logic is_ls_c, is_dr_c, done_c, wait_c, wd_clr_c, wd_expire_c;

  // Div/rem wins when an index falls in both ranges.
  assign is_dr_c = (i_instruction >= OPC_W'(DR_LO)) && (i_instruction <= OPC_W'(DR_HI));
  assign is_ls_c = (i_instruction >= OPC_W'(LS_LO)) && (i_instruction <= OPC_W'(LS_HI)) && !is_dr_c;

  always_comb begin
    done_c = 1'b0;
    if (state_q == S_EXECUTE) begin
      if (is_dr_c)      done_c = i_div_rem_finnished;
      else if (is_ls_c) done_c = i_bus_DV;
      else              done_c = 1'b1;
    end
  end

  assign wait_c = !i_bus_DV &&
                  ((state_q == S_FETCH) || ((state_q == S_EXECUTE) && is_ls_c));

  assign wd_clr_c = i_bus_DV || (state_d != state_q);

  bus_watchdog #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_bus_watchdog (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (wd_clr_c),
    .i_en       (wait_c),
    .o_expire_c (wd_expire_c)
  );

  always_comb begin
    state_d       = state_q;
    start_fetch_d = 1'b0;
    ack_m_d       = 1'b0;
    ack_s_d       = 1'b0;
    timeout_d     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (i_bus_DV) begin
          state_d = S_EXECUTE;
        end else if (wd_expire_c) begin
          state_d   = S_FAULT;
          timeout_d = 1'b1;
        end
      end
      S_EXECUTE: begin
        // Interrupts are only taken once the current instruction has completed.
        if (done_c) begin
          if (i_m_interrupt && i_m_ie) begin
            state_d = S_MTRAP;
            ack_m_d = 1'b1;
          end else if (i_s_interrupt && i_s_ie) begin
            state_d = S_STRAP;
            ack_s_d = 1'b1;
          end else begin
            state_d       = S_FETCH;
            start_fetch_d = 1'b1;
          end
        end else if (wd_expire_c) begin
          state_d   = S_FAULT;
          timeout_d = 1'b1;
        end
      end
      S_MTRAP, S_STRAP: begin
        if (i_interrupt_finnished) begin
          state_d       = S_FETCH;
          start_fetch_d = 1'b1;
        end
      end
      S_FAULT: begin
        if (i_fault_clear) begin
          state_d       = S_FETCH;
          start_fetch_d = 1'b1;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_FETCH;
      start_fetch_q <= 1'b0;
      ack_m_q       <= 1'b0;
      ack_s_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_fetch_q <= start_fetch_d;
      ack_m_q       <= ack_m_d;
      ack_s_q       <= ack_s_d;
      timeout_q     <= timeout_d;
    end
  end

  assign o_load_PC     = done_c;
  assign o_start_fetch = start_fetch_q;
  assign o_state       = 3'(state_q);
  assign o_irq_ack_m   = ack_m_q;
  assign o_irq_ack_s   = ack_s_q;
  assign o_bus_timeout = timeout_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_cpu_sequencer;

  localparam int unsigned TMO = 10;

  logic        clk = 1'b0;
  logic        rst, dv, fin, mi, si, mie, sie, ifin, fclr;
  logic [31:0] instr;
  logic        load_pc, start_fetch, ack_m, ack_s, bus_to;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: state number, cycles already spent waiting, expected pulses.
  int m_state = 0;
  int m_wait  = 0;
  bit m_sf = 0, m_am = 0, m_as = 0, m_to = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.TMO_MAX(TMO)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_bus_DV              (dv),
    .i_instruction         (instr),
    .i_div_rem_finnished   (fin),
    .i_m_interrupt         (mi),
    .i_s_interrupt         (si),
    .i_m_ie                (mie),
    .i_s_ie                (sie),
    .i_interrupt_finnished (ifin),
    .i_fault_clear         (fclr),
    .o_load_PC             (load_pc),
    .o_start_fetch         (start_fetch),
    .o_state               (state),
    .o_irq_ack_m           (ack_m),
    .o_irq_ack_s           (ack_s),
    .o_bus_timeout         (bus_to)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit in_dr(input int unsigned x);
    return (x >= 14) && (x <= 17);
  endfunction

  function automatic bit in_ls(input int unsigned x);
    return (x >= 27) && (x <= 34) && !in_dr(x);
  endfunction

  // One clock: drive at the falling edge, check, advance the model, cross the rising edge.
  task automatic cyc(input bit r, input bit d, input int unsigned ins, input bit f,
                     input bit m, input bit s, input bit me, input bit se,
                     input bit itf, input bit fc);
    bit done, waiting, sf, am, as_, to;
    int nxt, nw;
    rst = r; dv = d; instr = ins; fin = f; mi = m; si = s;
    mie = me; sie = se; ifin = itf; fclr = fc;
    #1;
    done = (m_state == 1) && (in_dr(ins) ? f : (in_ls(ins) ? d : 1'b1));
    chk("load_pc", 32'(load_pc), 32'(done));
    chk("state", 32'(state), 32'(m_state));
    chk("start_fetch", 32'(start_fetch), 32'(m_sf));
    chk("ack_m", 32'(ack_m), 32'(m_am));
    chk("ack_s", 32'(ack_s), 32'(m_as));
    chk("bus_timeout", 32'(bus_to), 32'(m_to));
    waiting = !d && ((m_state == 0) || ((m_state == 1) && in_ls(ins)));
    nxt = m_state; sf = 0; am = 0; as_ = 0; to = 0;
    if (waiting && (m_wait + 1 == int'(TMO)) && !done) begin
      nxt = 4; to = 1;
    end else begin
      case (m_state)
        0: if (d) nxt = 1;
        1: if (done) begin
             if (m && me)      begin nxt = 2; am = 1; end
             else if (s && se) begin nxt = 3; as_ = 1; end
             else              begin nxt = 0; sf = 1; end
           end
        2, 3: if (itf) begin nxt = 0; sf = 1; end
        4: if (fc) begin nxt = 0; sf = 1; end
        default: nxt = 0;
      endcase
    end
    if (nxt != m_state || d) nw = 0;
    else if (waiting)        nw = m_wait + 1;
    else                     nw = m_wait;
    if (r) begin
      nxt = 0; nw = 0; sf = 0; am = 0; as_ = 0; to = 0;
    end
    @(posedge clk);
    m_state = nxt; m_wait = nw; m_sf = sf; m_am = am; m_as = as_; m_to = to;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; dv = 0; instr = 0; fin = 0; mi = 0; si = 0;
    mie = 0; sie = 0; ifin = 0; fclr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_pulses", 32'({start_fetch, ack_m, ack_s, bus_to}), 32'd0);

    // ALU op: one EXECUTE cycle, then back to FETCH with a fetch request.
    cyc(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_exec", 32'(state), 32'd1);
    cyc(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_back", 32'(state), 32'd0);
    chk("alu_sf", 32'(start_fetch), 32'd1);

    // Load: held until the bus returns data four cycles after entry.
    cyc(0, 1, 27, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 27, 0, 0, 0, 0, 0, 0, 0);
      chk("ld_hold", 32'(state), 32'd1);
    end
    cyc(0, 1, 27, 0, 0, 0, 0, 0, 0, 0);
    chk("ld_done", 32'(state), 32'd0);

    // Div with machine interrupt pending throughout.
    cyc(0, 1, 15, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 15, 0, 1, 0, 1, 0, 0, 0);
      chk("div_hold", 32'(state), 32'd1);
    end
    cyc(0, 0, 15, 1, 1, 0, 1, 0, 0, 0);
    chk("div_mtrap", 32'(state), 32'd2);
    chk("div_ackm", 32'(ack_m), 32'd1);
    chk("div_nosf", 32'(start_fetch), 32'd0);
    cyc(0, 0, 15, 0, 1, 0, 1, 0, 0, 0);
    chk("ackm_once", 32'(ack_m), 32'd0);
    cyc(0, 0, 15, 0, 1, 0, 1, 0, 1, 0);
    chk("mtrap_exit", 32'(state), 32'd0);

    // Both pending, machine disabled -> supervisor trap; then both disabled.
    cyc(0, 1, 16, 0, 1, 1, 0, 1, 0, 0);
    cyc(0, 0, 16, 1, 1, 1, 0, 1, 0, 0);
    chk("strap", 32'(state), 32'd3);
    chk("acks", 32'(ack_s), 32'd1);
    cyc(0, 0, 16, 0, 1, 1, 0, 1, 1, 0);
    cyc(0, 1, 16, 0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 16, 1, 1, 1, 0, 0, 0, 0);
    chk("no_irq", 32'(state), 32'd0);

    // Watchdog expiry in FETCH, then clear, then data in the expiry cycle.
    for (int i = 0; i < int'(TMO) - 1; i++) cyc(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("wd_pre", 32'(state), 32'd0);
    cyc(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("wd_fault", 32'(state), 32'd4);
    chk("wd_pulse", 32'(bus_to), 32'd1);
    cyc(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("fault_ign_dv", 32'(state), 32'd4);
    cyc(0, 0, 5, 0, 0, 0, 0, 0, 0, 1);
    chk("fault_clr", 32'(state), 32'd0);
    for (int i = 0; i < int'(TMO) - 1; i++) cyc(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("wd_dv_wins", 32'(state), 32'd1);
    chk("wd_no_pulse", 32'(bus_to), 32'd0);
    cyc(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a load clears state and the watchdog.
    cyc(0, 1, 30, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 30, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 30, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 30, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pulses", 32'({start_fetch, ack_m, ack_s, bus_to}), 32'd0);
    for (int i = 0; i < int'(TMO) - 1; i++) cyc(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_wd_cleared", 32'(state), 32'd0);
    cyc(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_wd_full", 32'(state), 32'd4);
    cyc(0, 0, 5, 0, 0, 0, 0, 0, 0, 1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 40),
          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Parametrised successor to the CPU's FETCH/EXECUTE control unit. Sequences fetch and execute, and holds EXECUTE for long-latency instruction classes: load/store until the bus returns valid data, and div/rem until the divider finishes. Takes machine or supervisor interrupts only at instruction boundaries, with enable gating, and adds a bus watchdog that raises a fault state.

Parameters:
OPC_W, 32, width of the decoded instruction-index input
LS_LO, 27, first load/store instruction index (inclusive)
LS_HI, 34, last load/store instruction index (inclusive)
DR_LO, 14, first div/rem instruction index (inclusive)
DR_HI, 17, last div/rem instruction index (inclusive)
TMO_W, 8, width of the bus watchdog counter
TMO_MAX, 200, bus-wait cycles before fault; must be nonzero and below 2**TMO_W

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_bus_DV  in  1  bus data valid, single-cycle pulse
i_instruction  in  OPC_W  decoded instruction index
i_div_rem_finnished  in  1  divider done pulse
i_m_interrupt  in  1  machine interrupt pending, level
i_s_interrupt  in  1  supervisor interrupt pending, level
i_m_ie  in  1  machine interrupt enable
i_s_ie  in  1  supervisor interrupt enable
i_interrupt_finnished  in  1  trap entry complete pulse
i_fault_clear  in  1  leave FAULT state
o_load_PC  out  1  PC update strobe, combinational
o_start_fetch  out  1  one-cycle fetch request, registered
o_state  out  3  current state encoding
o_irq_ack_m  out  1  one-cycle pulse on machine trap entry
o_irq_ack_s  out  1  one-cycle pulse on supervisor trap entry
o_bus_timeout  out  1  one-cycle pulse when the watchdog expires

Behaviour:
- States: FETCH=0, EXECUTE=1, MTRAP=2, STRAP=3, FAULT=4.
- Reset: state=FETCH, watchdog counter=0, all registered outputs 0. Reset overrides every event in the same cycle.
- Classes: ls = LS_LO<=instr<=LS_HI; dr = DR_LO<=instr<=DR_HI. An index in both ranges is treated as dr.
- done = EXECUTE & (dr ? i_div_rem_finnished : ls ? i_bus_DV : 1).
- o_load_PC = done. This is combinational and has the same cycle as done.
- FETCH: on i_bus_DV go to EXECUTE. Otherwise increment the watchdog.
- EXECUTE (ls only): increment the watchdog while waiting for i_bus_DV.
- EXECUTE with done, interrupt priority:
  - If i_m_interrupt & i_m_ie: go to MTRAP and pulse o_irq_ack_m next cycle.
  - Else if i_s_interrupt & i_s_ie: go to STRAP and pulse o_irq_ack_s.
  - Else: go to FETCH and pulse o_start_fetch.
- Interrupts never abort an incomplete instruction. A pending interrupt with done=0 has no effect.
- MTRAP/STRAP: on i_interrupt_finnished go to FETCH and pulse o_start_fetch. No nested interrupts are taken.
- Watchdog: cleared on every state change and on every i_bus_DV.
  - When the counter equals TMO_MAX-1 and the next increment is due: go to FAULT and pulse o_bus_timeout.
  - Timeout fires exactly TMO_MAX cycles after entering the waiting state.
  - i_bus_DV arriving in the expiry cycle wins; no fault is raised.
- FAULT: o_load_PC=0, bus pulses are ignored. On i_fault_clear go to FETCH and pulse o_start_fetch.
- Non-ls, non-dr instructions complete in one EXECUTE cycle.
- The counter saturates and never wraps.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encoding localparams;
  - default class-range constants;
  - TMO defaults.
- Sub-module bus_watchdog (counter, clear, enable, expiry pulse), parametrised by TMO_W/TMO_MAX.
- Classification stays inline.

Test Plan:
- ALU op (instr=5): DV in FETCH -> EXECUTE one cycle with o_load_PC=1 -> FETCH, o_start_fetch pulses once.
- Load (instr=27), DV 4 cycles after EXECUTE entry -> o_load_PC only in the DV cycle, state stays 1 for 4 cycles.
- Div (instr=15) with i_m_interrupt=1, i_m_ie=1 held from cycle 1, finish at cycle 6:
  - state stays 1 until cycle 6, then goes to 2;
  - o_irq_ack_m pulses once, no o_start_fetch;
  - i_interrupt_finnished -> FETCH.
- Both interrupts at completion with i_m_ie=0, i_s_ie=1 -> STRAP (3), o_irq_ack_s pulses. Repeat with both disabled -> FETCH.
- Watchdog with TMO_MAX=10, no DV in FETCH:
  - o_bus_timeout pulses at cycle 10, state=4;
  - i_fault_clear -> FETCH;
  - repeat with DV at cycle 10 -> no fault.
- i_rst asserted mid-EXECUTE of a load -> next cycle state=0, counter=0, no pulses.
